// File: rtl/video_timing_sequencer.sv
// rtl/video_timing_sequencer.sv - line/field/frame timing generator for the composite encoder path
module video_timing_sequencer #(
    parameter int H_TOTAL_PAL  = 3072,
    parameter int H_TOTAL_NTSC = 3051,
    parameter int SYNC_LEN     = 225,
    parameter int BURST_START  = 270,
    parameter int ACTIVE_START = 500,
    parameter int ACTIVE_END   = 3000,
    parameter int VBLANK_LINES = 22,
    parameter int VSYNC_LINES  = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        pal_mode_req,
    output logic        pal_mode,
    output logic [11:0] h_pos,
    output logic [9:0]  line_pos,
    output logic        newframe,
    output logic        newline,
    output logic        even_line,
    output logic        even_field,
    output logic        startburst,
    output logic        sync,
    output logic        blank,
    output logic        active
);

    if (H_TOTAL_PAL > 4095 || H_TOTAL_NTSC > 4095 || ACTIVE_END > 4095 ||
        H_TOTAL_PAL < 2 || H_TOTAL_NTSC < 2 || VBLANK_LINES > 1023 ||
        VSYNC_LINES + 6 > 1023) begin : g_width_check
        $error("video_timing_sequencer: parameter exceeds counter width");
    end

    localparam logic [11:0] HT_PAL       = 12'(H_TOTAL_PAL);
    localparam logic [11:0] HT_NTSC      = 12'(H_TOTAL_NTSC);
    localparam logic [11:0] SYNC_L       = 12'(SYNC_LEN);
    localparam logic [11:0] BURST_H      = 12'(BURST_START);
    localparam logic [11:0] ACT_S        = 12'(ACTIVE_START);
    localparam logic [11:0] ACT_E_PAL    = 12'(ACTIVE_END);
    localparam logic [11:0] ACT_E_NTSC   = (ACTIVE_END > H_TOTAL_NTSC - 1) ?
                                           12'(H_TOTAL_NTSC - 1) : 12'(ACTIVE_END);
    localparam logic [9:0]  F0_PAL       = 10'd313;
    localparam logic [9:0]  F0_NTSC      = 10'd263;
    localparam logic [9:0]  FR_PAL       = 10'd625;
    localparam logic [9:0]  FR_NTSC      = 10'd525;
    localparam logic [9:0]  VS_L         = 10'(VSYNC_LINES);
    localparam logic [9:0]  VB_L         = 10'(VBLANK_LINES);
    localparam logic [9:0]  BURST_LIF    = 10'(VSYNC_LINES + 6);

    logic        started;
    logic [11:0] nxt_h;
    logic [9:0]  nxt_line;
    logic        nxt_pal;
    logic [11:0] htot, half, aend;
    logic [9:0]  f0, lif;
    logic        d_sync, d_blank, d_burst, d_newline, d_newframe;

    // The first enabled cycle after reset presents position 0 with its pulses instead of advancing.
    always_comb begin
        nxt_h    = h_pos;
        nxt_line = line_pos;
        nxt_pal  = pal_mode;
        if (!started) begin
            nxt_h    = '0;
            nxt_line = '0;
        end else if (h_pos == (pal_mode ? HT_PAL : HT_NTSC) - 12'd1) begin
            nxt_h = '0;
            if (line_pos == (pal_mode ? FR_PAL : FR_NTSC) - 10'd1) begin
                nxt_line = '0;
                nxt_pal  = pal_mode_req;
            end else begin
                nxt_line = line_pos + 10'd1;
            end
        end else begin
            nxt_h = h_pos + 12'd1;
        end
    end

    // Decode the upcoming position so every registered flag lines up with its h_pos/line_pos.
    always_comb begin
        htot       = nxt_pal ? HT_PAL : HT_NTSC;
        half       = htot >> 1;
        aend       = nxt_pal ? ACT_E_PAL : ACT_E_NTSC;
        f0         = nxt_pal ? F0_PAL : F0_NTSC;
        lif        = (nxt_line < f0) ? nxt_line : nxt_line - f0;
        d_sync     = (lif < VS_L) ?
                     ((nxt_h < half - SYNC_L) || (nxt_h >= half && nxt_h < htot - SYNC_L)) :
                     (nxt_h < SYNC_L);
        d_blank    = (lif < VB_L) || (nxt_h < ACT_S) || (nxt_h >= aend);
        d_burst    = (nxt_h == BURST_H) && (lif >= BURST_LIF);
        d_newline  = (nxt_h == 12'd0);
        d_newframe = (nxt_h == 12'd0) && (nxt_line == 10'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            started    <= 1'b0;
            pal_mode   <= pal_mode_req;
            h_pos      <= '0;
            line_pos   <= '0;
            newframe   <= 1'b0;
            newline    <= 1'b0;
            startburst <= 1'b0;
            sync       <= 1'b0;
            blank      <= 1'b1;
            active     <= 1'b0;
            even_field <= 1'b1;
            even_line  <= 1'b1;
        end else if (enable) begin
            started    <= 1'b1;
            pal_mode   <= nxt_pal;
            h_pos      <= nxt_h;
            line_pos   <= nxt_line;
            newframe   <= d_newframe;
            newline    <= d_newline;
            startburst <= d_burst;
            sync       <= d_sync;
            blank      <= d_blank;
            active     <= ~d_blank;
            even_field <= (nxt_line < f0);
            even_line  <= ~nxt_line[0];
        end else begin
            newframe   <= 1'b0;
            newline    <= 1'b0;
            startburst <= 1'b0;
        end
    end

endmodule
